data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single data memory port between two requesters: the core load/store path (port CORE) and the debug/program loader (port DBG).
- Uses valid/ready request handshakes and round-robin fairness.
- DBG can take a starvation-bounded priority lock for bulk loads.
- Drives the memory's addr, wr_data and wr_sel combinationally; returns a registered response one cycle after each accepted request.

Parameters:
- MAX_LOCK_CYCLES, 16, max consecutive cycles CORE may be denied while DBG holds the lock; minimum 1.
- CNT_W, $clog2(MAX_LOCK_CYCLES+1), width of the starvation counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- core_req_valid  in  1  CORE request valid
- core_req_ready  out  1  CORE request accepted this cycle
- core_addr  in  32 (word_t)  CORE byte address
- core_wr_data  in  32 (word_t)  CORE write data
- core_wr_sel  in  4 (byte_sel_t)  CORE byte write enables; 4'b0000 means read
- core_rsp_valid  out  1  CORE response valid, 1-cycle pulse
- core_rsp_data  out  32 (word_t)  CORE read data
- dbg_req_valid, dbg_req_ready, dbg_addr, dbg_wr_data, dbg_wr_sel, dbg_rsp_valid, dbg_rsp_data: same as the CORE set, for DBG
- dbg_lock  in  1  DBG requests priority lock
- mem_addr  out  32  to data memory addr
- mem_wr_data  out  32  to data memory wr_data
- mem_wr_sel  out  4  to data memory wr_sel
- mem_rd_data  in  32  combinational read data from data memory

Behaviour:
- Transfer: req_valid && req_ready at a posedge. At most one transfer per cycle. Ready is combinational from the current grant decision; ready is never asserted without the matching valid.
- mem_addr and mem_wr_data mux from the granted port; both are 0 when there is no grant. mem_wr_sel = granted port's wr_sel only on a transfer, else 4'b0000. The write commits at that posedge.
- Response:
  - On a read transfer (wr_sel==0), mem_rd_data is captured at the same edge; rsp_valid for that port is high for exactly the next cycle.
  - A write transfer also pulses rsp_valid (write ack), with rsp_data = 0.
  - rsp_data holds its value when rsp_valid is low.
  - No backpressure on responses.
- State machine, arb_state_t {ARB_RR, ARB_LOCKED}:
  - ARB_RR, both valid: grant the port not in last_grant. One valid: grant it. last_grant updates on every transfer.
  - ARB_RR -> ARB_LOCKED: on a DBG transfer with dbg_lock=1.
  - ARB_LOCKED, grant rule: DBG wins whenever dbg_req_valid, unless starve_cnt==MAX_LOCK_CYCLES. In that case CORE is granted (if valid) and starve_cnt clears.
  - ARB_LOCKED, counting: starve_cnt increments each cycle core_req_valid is high and CORE is not granted. It clears on any CORE transfer or when core_req_valid is low.
  - ARB_LOCKED -> ARB_RR: any cycle dbg_lock is sampled low. The grant in that cycle already uses RR rules; starve_cnt clears.
- Reset (async, rst_n low), applied immediately:
  - state=ARB_RR, last_grant=DBG (CORE wins the first tie), starve_cnt=0.
  - rsp_valid=0, rsp_data=0 on both ports.
  - Both ready=0, mem_wr_sel=0 while rst_n low, so no write can commit.
  - A response pending at reset assertion is dropped.
- Addresses pass through unchecked. Out-of-range and misaligned addresses are handled downstream; the arbiter adds no wrap logic.
- A requester must hold valid, addr, wr_data and wr_sel stable until ready. An assertion flags a violation.

Decomposition:
- riscv_32i_control_pkg: arb_state_t, arb_port_t enum {ARB_CORE, ARB_DBG}.
- riscv_32i_config_pkg: DATA_MEM_ARB_MAX_LOCK constant, used as the default for MAX_LOCK_CYCLES.
- Reuse word_t and byte_sel_t from riscv_32i_defs_pkg.
- One sub-module: arb_grant_2. This is the combinational grant-decision logic (state, last_grant, starve_cnt, valids -> one-hot grant). It is unit-testable in isolation.
- Counters, FSM, response registers and muxes stay in data_mem_arbiter.

Test Plan:
1. Reset then tie:
   - Stimulus: both valid, reads at addresses 0x10 (CORE) and 0x20 (DBG), dbg_lock=0.
   - Required: cycle 0 grants CORE, cycle 1 grants DBG. core_rsp_valid pulses in cycle 1, dbg_rsp_valid in cycle 2, each with correct data.
2. Write then read:
   - Stimulus: CORE writes 0xDEADBEEF to 0x40 with wr_sel=4'b1111, then reads 0x40.
   - Required: ack with rsp_data=0, then rsp_data=0xDEADBEEF. mem_wr_sel is 0 on every non-transfer cycle.
3. Lock starvation bound (MAX_LOCK_CYCLES=4):
   - Stimulus: DBG streams with dbg_lock=1 while CORE is continuously valid.
   - Required: CORE is denied exactly 4 cycles, granted on the 5th, then DBG resumes.
4. Lock release:
   - Stimulus: drop dbg_lock while both are valid.
   - Required: the same cycle reverts to round-robin; the next grant alternates away from last_grant.
5. Async reset mid-write:
   - Stimulus: assert rst_n low between edges while DBG write 4'b0011 to 0x80 is valid.
   - Required: mem_wr_sel=0 immediately; memory at 0x80 unchanged; all rsp_valid=0; after release CORE wins the first tie.
6. Single requester back-to-back:
   - Stimulus: DBG valid for 8 cycles, CORE idle.
   - Required: 8 consecutive transfers and 8 consecutive dbg_rsp_valid pulses, no bubbles.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data memory arbiter slice.
package data_mem_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  byte_sel_t;

  typedef enum logic {
    ARB_RR,
    ARB_LOCKED
  } arb_state_t;

  typedef enum logic {
    ARB_CORE,
    ARB_DBG
  } arb_port_t;

  localparam int unsigned DATA_MEM_ARB_MAX_LOCK = 16;

  // A request with no byte enables set is a read.
  function automatic logic is_read(input byte_sel_t sel);
    return (sel == 4'b0000);
  endfunction

endpackage

// File: rtl/data_mem_arbiter_grant.sv
// Combinational two-way grant decision: round-robin, or DBG-priority lock
// with a bound on how long CORE can be held off.
module arb_grant_2
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LOCK_CYCLES = DATA_MEM_ARB_MAX_LOCK,
  parameter int unsigned CNT_W           = $clog2(MAX_LOCK_CYCLES + 1)
) (
  input  logic             locked_i,
  input  logic             dbg_lock_i,
  input  logic             last_dbg_i,
  input  logic [CNT_W-1:0] starve_cnt_i,
  input  logic             core_valid_i,
  input  logic             dbg_valid_i,
  output logic [1:0]       grant_o
);

  logic lock_active;
  logic starved;

  assign lock_active = locked_i && dbg_lock_i;
  assign starved     = (starve_cnt_i == CNT_W'(MAX_LOCK_CYCLES));

  // grant_o[0] = CORE, grant_o[1] = DBG; a grant is only ever given to a valid port.
  always_comb begin
    grant_o = 2'b00;
    if (lock_active) begin
      if (starved && core_valid_i)  grant_o = 2'b01;
      else if (dbg_valid_i)         grant_o = 2'b10;
      else if (core_valid_i)        grant_o = 2'b01;
    end else begin
      if (core_valid_i && dbg_valid_i) grant_o = last_dbg_i ? 2'b01 : 2'b10;
      else if (core_valid_i)           grant_o = 2'b01;
      else if (dbg_valid_i)            grant_o = 2'b10;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single data memory port between the core load/store path
// and the debug loader; registered responses one cycle after each transfer.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LOCK_CYCLES = DATA_MEM_ARB_MAX_LOCK,
  parameter int unsigned CNT_W           = $clog2(MAX_LOCK_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req_valid,
  output logic        core_req_ready,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wr_data,
  input  logic [3:0]  core_wr_sel,
  output logic        core_rsp_valid,
  output logic [31:0] core_rsp_data,
  input  logic        dbg_req_valid,
  output logic        dbg_req_ready,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wr_data,
  input  logic [3:0]  dbg_wr_sel,
  output logic        dbg_rsp_valid,
  output logic [31:0] dbg_rsp_data,
  input  logic        dbg_lock,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_sel,
  input  logic [31:0] mem_rd_data
);

  arb_state_t       state_q, state_d;
  arb_port_t        last_grant_q, last_grant_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [1:0]       grant;
  logic             core_xfer, dbg_xfer;
  logic             core_rsp_valid_q, dbg_rsp_valid_q;
  word_t            core_rsp_data_q, dbg_rsp_data_q;

  arb_grant_2 #(
    .MAX_LOCK_CYCLES(MAX_LOCK_CYCLES),
    .CNT_W          (CNT_W)
  ) u_grant (
    .locked_i    (state_q == ARB_LOCKED),
    .dbg_lock_i  (dbg_lock),
    .last_dbg_i  (last_grant_q == ARB_DBG),
    .starve_cnt_i(starve_cnt_q),
    .core_valid_i(core_req_valid),
    .dbg_valid_i (dbg_req_valid),
    .grant_o     (grant)
  );

  // Ready and write enables are gated by rst_n so nothing commits while reset is held.
  always_comb begin
    core_req_ready = grant[0] && rst_n;
    dbg_req_ready  = grant[1] && rst_n;
    core_xfer      = core_req_valid && core_req_ready;
    dbg_xfer       = dbg_req_valid && dbg_req_ready;
    mem_addr       = '0;
    mem_wr_data    = '0;
    mem_wr_sel     = 4'b0000;
    if (grant[0]) begin
      mem_addr    = core_addr;
      mem_wr_data = core_wr_data;
    end else if (grant[1]) begin
      mem_addr    = dbg_addr;
      mem_wr_data = dbg_wr_data;
    end
    if (core_xfer)     mem_wr_sel = core_wr_sel;
    else if (dbg_xfer) mem_wr_sel = dbg_wr_sel;
  end

  // Next-state: lock entry on a locked DBG transfer, release whenever dbg_lock drops.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    starve_cnt_d = '0;
    if (core_xfer)     last_grant_d = ARB_CORE;
    else if (dbg_xfer) last_grant_d = ARB_DBG;
    case (state_q)
      ARB_RR: begin
        if (dbg_xfer && dbg_lock) state_d = ARB_LOCKED;
      end
      ARB_LOCKED: begin
        if (!dbg_lock) begin
          state_d = ARB_RR;
        end else if (core_req_valid && !core_xfer) begin
          starve_cnt_d = (starve_cnt_q == CNT_W'(MAX_LOCK_CYCLES)) ? starve_cnt_q
                                                                    : starve_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ARB_RR;
    endcase
  end

  // Arbitration state registers; last_grant resets to DBG so CORE wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_RR;
      last_grant_q <= ARB_DBG;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Response registers: reads capture memory data, writes return zero; data holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rsp_valid_q <= 1'b0;
      dbg_rsp_valid_q  <= 1'b0;
      core_rsp_data_q  <= '0;
      dbg_rsp_data_q   <= '0;
    end else begin
      core_rsp_valid_q <= core_xfer;
      dbg_rsp_valid_q  <= dbg_xfer;
      if (core_xfer) core_rsp_data_q <= is_read(core_wr_sel) ? mem_rd_data : '0;
      if (dbg_xfer)  dbg_rsp_data_q  <= is_read(dbg_wr_sel)  ? mem_rd_data : '0;
    end
  end

  assign core_rsp_valid = core_rsp_valid_q;
  assign core_rsp_data  = core_rsp_data_q;
  assign dbg_rsp_valid  = dbg_rsp_valid_q;
  assign dbg_rsp_data   = dbg_rsp_data_q;

  // A waiting requester must keep its request unchanged until it is accepted.
  property p_hold_core;
    @(posedge clk) disable iff (!rst_n)
      (core_req_valid && !core_req_ready) |=>
        (core_req_valid && $stable(core_addr) && $stable(core_wr_data) && $stable(core_wr_sel));
  endproperty

  property p_hold_dbg;
    @(posedge clk) disable iff (!rst_n)
      (dbg_req_valid && !dbg_req_ready) |=>
        (dbg_req_valid && $stable(dbg_addr) && $stable(dbg_wr_data) && $stable(dbg_wr_sel));
  endproperty

  a_hold_core: assert property (p_hold_core);
  a_hold_dbg:  assert property (p_hold_dbg);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small byte-writable memory model.
module tb_data_mem_arbiter;

  typedef struct {
    logic        cv;
    logic [31:0] ca, cd;
    logic [3:0]  cs;
    logic        dv;
    logic [31:0] da, dd;
    logic [3:0]  ds;
    logic        lk;
    logic        ecr, edr;
    logic [3:0]  ews;
    logic        ecrv;
    logic [31:0] ecrd;
    logic        edrv;
    logic [31:0] edrd;
  } vec_t;

  localparam int NVEC = 31;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req_valid, core_req_ready;
  logic [31:0] core_addr, core_wr_data;
  logic [3:0]  core_wr_sel;
  logic        core_rsp_valid;
  logic [31:0] core_rsp_data;
  logic        dbg_req_valid, dbg_req_ready;
  logic [31:0] dbg_addr, dbg_wr_data;
  logic [3:0]  dbg_wr_sel;
  logic        dbg_rsp_valid;
  logic [31:0] dbg_rsp_data;
  logic        dbg_lock;
  logic [31:0] mem_addr, mem_wr_data;
  logic [3:0]  mem_wr_sel;
  logic [31:0] mem_rd_data;

  logic [31:0] mem [64];
  logic        memReady = 1'b0;

  int assertionsEvaluated = 0;
  int failures = 0;

  vec_t vecs [NVEC];

  data_mem_arbiter #(.MAX_LOCK_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .core_req_valid(core_req_valid),
    .core_req_ready(core_req_ready),
    .core_addr     (core_addr),
    .core_wr_data  (core_wr_data),
    .core_wr_sel   (core_wr_sel),
    .core_rsp_valid(core_rsp_valid),
    .core_rsp_data (core_rsp_data),
    .dbg_req_valid (dbg_req_valid),
    .dbg_req_ready (dbg_req_ready),
    .dbg_addr      (dbg_addr),
    .dbg_wr_data   (dbg_wr_data),
    .dbg_wr_sel    (dbg_wr_sel),
    .dbg_rsp_valid (dbg_rsp_valid),
    .dbg_rsp_data  (dbg_rsp_data),
    .dbg_lock      (dbg_lock),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_sel    (mem_wr_sel),
    .mem_rd_data   (mem_rd_data)
  );

  always #5 clk = ~clk;

  // Memory model: word i starts as 0xA5000000+i, byte-enabled writes at the clock edge.
  always @(posedge clk) begin
    if (!memReady) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 + 32'(i);
      memReady <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_wr_sel[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
    end
  end

  assign mem_rd_data = mem[mem_addr[7:2]];

  function automatic vec_t mk(input logic cv, input logic [31:0] ca, input logic [31:0] cd,
                              input logic [3:0] cs, input logic dv, input logic [31:0] da,
                              input logic [31:0] dd, input logic [3:0] ds, input logic lk,
                              input logic ecr, input logic edr, input logic [3:0] ews,
                              input logic ecrv, input logic [31:0] ecrd,
                              input logic edrv, input logic [31:0] edrd);
    vec_t v;
    v.cv = cv; v.ca = ca; v.cd = cd; v.cs = cs;
    v.dv = dv; v.da = da; v.dd = dd; v.ds = ds; v.lk = lk;
    v.ecr = ecr; v.edr = edr; v.ews = ews;
    v.ecrv = ecrv; v.ecrd = ecrd; v.edrv = edrv; v.edrd = edrd;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    core_req_valid = v.cv; core_addr = v.ca; core_wr_data = v.cd; core_wr_sel = v.cs;
    dbg_req_valid  = v.dv; dbg_addr  = v.da; dbg_wr_data  = v.dd; dbg_wr_sel  = v.ds;
    dbg_lock       = v.lk;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertionsEvaluated++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("v%0d_core_ready", i), 32'(core_req_ready), 32'(v.ecr));
    checkOutput($sformatf("v%0d_dbg_ready", i),  32'(dbg_req_ready),  32'(v.edr));
    checkOutput($sformatf("v%0d_mem_wr_sel", i), 32'(mem_wr_sel),     32'(v.ews));
    checkOutput($sformatf("v%0d_core_rsp_valid", i), 32'(core_rsp_valid), 32'(v.ecrv));
    checkOutput($sformatf("v%0d_core_rsp_data", i),  core_rsp_data,       v.ecrd);
    checkOutput($sformatf("v%0d_dbg_rsp_valid", i),  32'(dbg_rsp_valid),  32'(v.edrv));
    checkOutput($sformatf("v%0d_dbg_rsp_data", i),   dbg_rsp_data,        v.edrd);
  endtask

  initial begin
    // Reset, tie, CORE wins first; held CORE request then wins the next slot.
    vecs[0]  = mk(1, 32'h10, 0, 0,            1, 32'h20, 0, 0, 0,  1, 0, 4'h0,  0, 0,            0, 0);
    vecs[1]  = mk(1, 32'h14, 0, 0,            1, 32'h20, 0, 0, 0,  0, 1, 4'h0,  1, 32'hA5000004, 0, 0);
    vecs[2]  = mk(1, 32'h14, 0, 0,            0, 0, 0, 0, 0,       1, 0, 4'h0,  0, 32'hA5000004, 1, 32'hA5000008);
    vecs[3]  = mk(0, 0, 0, 0,                 0, 0, 0, 0, 0,       0, 0, 4'h0,  1, 32'hA5000005, 0, 32'hA5000008);
    // CORE full write then read back; DBG partial write then read back.
    vecs[4]  = mk(1, 32'h40, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0,    1, 0, 4'hF,  0, 32'hA5000005, 0, 32'hA5000008);
    vecs[5]  = mk(1, 32'h40, 0, 0,            0, 0, 0, 0, 0,       1, 0, 4'h0,  1, 0,            0, 32'hA5000008);
    vecs[6]  = mk(0, 0, 0, 0,                 0, 0, 0, 0, 0,       0, 0, 4'h0,  1, 32'hDEADBEEF, 0, 32'hA5000008);
    vecs[7]  = mk(0, 0, 0, 0,  1, 32'h44, 32'h11223344, 4'h3, 0,   0, 1, 4'h3,  0, 32'hDEADBEEF, 0, 32'hA5000008);
    vecs[8]  = mk(0, 0, 0, 0,                 1, 32'h44, 0, 0, 0,  0, 1, 4'h0,  0, 32'hDEADBEEF, 1, 0);
    vecs[9]  = mk(0, 0, 0, 0,                 0, 0, 0, 0, 0,       0, 0, 4'h0,  0, 32'hDEADBEEF, 1, 32'hA5003344);
    // Lock entry, CORE denied four cycles then granted on the fifth.
    vecs[10] = mk(0, 0, 0, 0,                 1, 32'h20, 0, 0, 1,  0, 1, 4'h0,  0, 32'hDEADBEEF, 0, 32'hA5003344);
    vecs[11] = mk(1, 32'h10, 0, 0,            1, 32'h24, 0, 0, 1,  0, 1, 4'h0,  0, 32'hDEADBEEF, 1, 32'hA5000008);
    vecs[12] = mk(1, 32'h10, 0, 0,            1, 32'h24, 0, 0, 1,  0, 1, 4'h0,  0, 32'hDEADBEEF, 1, 32'hA5000009);
    vecs[13] = mk(1, 32'h10, 0, 0,            1, 32'h24, 0, 0, 1,  0, 1, 4'h0,  0, 32'hDEADBEEF, 1, 32'hA5000009);
    vecs[14] = mk(1, 32'h10, 0, 0,            1, 32'h24, 0, 0, 1,  0, 1, 4'h0,  0, 32'hDEADBEEF, 1, 32'hA5000009);
    vecs[15] = mk(1, 32'h10, 0, 0,            1, 32'h24, 0, 0, 1,  1, 0, 4'h0,  0, 32'hDEADBEEF, 1, 32'hA5000009);
    vecs[16] = mk(0, 0, 0, 0,                 1, 32'h24, 0, 0, 1,  0, 1, 4'h0,  1, 32'hA5000004, 0, 32'hA5000009);
    // Lock release: same cycle falls back to round-robin, then alternates.
    vecs[17] = mk(1, 32'h14, 0, 0,            1, 32'h24, 0, 0, 1,  0, 1, 4'h0,  0, 32'hA5000004, 1, 32'hA5000009);
    vecs[18] = mk(1, 32'h14, 0, 0,            1, 32'h24, 0, 0, 0,  1, 0, 4'h0,  0, 32'hA5000004, 1, 32'hA5000009);
    vecs[19] = mk(1, 32'h18, 0, 0,            1, 32'h24, 0, 0, 0,  0, 1, 4'h0,  1, 32'hA5000005, 0, 32'hA5000009);
    vecs[20] = mk(1, 32'h18, 0, 0,            0, 0, 0, 0, 0,       1, 0, 4'h0,  0, 32'hA5000005, 1, 32'hA5000009);
    vecs[21] = mk(0, 0, 0, 0,                 0, 0, 0, 0, 0,       0, 0, 4'h0,  1, 32'hA5000006, 0, 32'hA5000009);
    // DBG alone for eight back-to-back reads of words 0..7.
    for (int k = 0; k < 8; k++)
      vecs[22+k] = mk(0, 0, 0, 0, 1, 32'(4*k), 0, 0, 0, 0, 1, 4'h0, 0, 32'hA5000006,
                      (k != 0), (k == 0) ? 32'hA5000009 : 32'hA5000000 + 32'(k-1));
    vecs[30] = mk(0, 0, 0, 0,                 0, 0, 0, 0, 0,       0, 0, 4'h0,  0, 32'hA5000006, 1, 32'hA5000007);

    rst_n = 1'b0;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_core_rsp_valid", 32'(core_rsp_valid), 32'd0);
    checkOutput("reset_dbg_rsp_data", dbg_rsp_data, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkVector(i, vecs[i]);
      @(posedge clk);
      #1;
    end

    // Async reset while a DBG write is being offered, with a CORE response in flight.
    applyStimulus(mk(1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    checkOutput("rst_pre_core_ready", 32'(core_req_ready), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(mk(0, 0, 0, 0, 1, 32'h80, 32'hFFFFFFFF, 4'h3, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkOutput("rst_pre_core_rsp_valid", 32'(core_rsp_valid), 32'd1);
    checkOutput("rst_pre_dbg_ready", 32'(dbg_req_ready), 32'd1);
    checkOutput("rst_pre_mem_wr_sel", 32'(mem_wr_sel), 32'h3);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mem_wr_sel", 32'(mem_wr_sel), 32'd0);
    checkOutput("rst_dbg_ready", 32'(dbg_req_ready), 32'd0);
    checkOutput("rst_core_rsp_valid", 32'(core_rsp_valid), 32'd0);
    checkOutput("rst_core_rsp_data", core_rsp_data, 32'd0);
    checkOutput("rst_dbg_rsp_valid", 32'(dbg_rsp_valid), 32'd0);
    checkOutput("rst_dbg_rsp_data", dbg_rsp_data, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_mem_0x80_unchanged", mem[32], 32'hA5000020);
    rst_n = 1'b1;
    applyStimulus(mk(1, 32'h10, 0, 0, 1, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    checkOutput("post_rst_tie_core_ready", 32'(core_req_ready), 32'd1);
    checkOutput("post_rst_tie_dbg_ready", 32'(dbg_req_ready), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(mk(0, 0, 0, 0, 1, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("post_rst_core_rsp_valid", 32'(core_rsp_valid), 32'd1);
    checkOutput("post_rst_core_rsp_data", core_rsp_data, 32'hA5000004);
    @(negedge clk);
    checkOutput("post_rst_dbg_ready", 32'(dbg_req_ready), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("post_rst_dbg_rsp_valid", 32'(dbg_rsp_valid), 32'd1);
    checkOutput("post_rst_dbg_rsp_data", dbg_rsp_data, 32'hA5000008);
    checkOutput("post_rst_core_rsp_end", 32'(core_rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertionsEvaluated, failures);
    $finish;
  end

endmodule
